data_mem_master: RTL and testbench

//  Initiator for the 16-bit data memory: accepts load/store requests from the core
//  and drives the memory's address / write-data / write-enable pins, capturing read data.

---
 rtl/data_mem_master.sv | 124 ++++++++++++
 tb/tb_data_mem_master.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_master.sv
// Initiator for the 16-bit data memory: single-word writes and incrementing burst reads.
// Read data is captured into a one-entry response register with valid/ready backpressure.
module data_mem_master #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned LEN_W  = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    input  logic [LEN_W-1:0]  req_len_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [DATA_W-1:0] resp_rdata_o,
    output logic              wr_done_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_we_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StWrite = 2'd1;
    localparam logic [1:0] StRead  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              wr_done_q, wr_done_d;
    logic              capture;

    // Response slot is free, or being drained this cycle.
    assign capture = !resp_valid_q || resp_ready_i;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_we_d     = mem_we_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        wr_done_d    = 1'b0;

        case (state_q)
            StIdle: begin
                if (resp_ready_i) resp_valid_d = 1'b0;
                if (req_valid_i) begin
                    mem_addr_d = req_addr_i;
                    if (req_we_i) begin
                        mem_wdata_d = req_wdata_i;
                        mem_we_d    = 1'b1;
                        state_d     = StWrite;
                    end else begin
                        mem_we_d = 1'b0;
                        cnt_d    = req_len_i;
                        state_d  = StRead;
                    end
                end
            end
            StWrite: begin
                if (resp_ready_i) resp_valid_d = 1'b0;
                mem_we_d  = 1'b0;
                wr_done_d = 1'b1;
                state_d   = StIdle;
            end
            StRead: begin
                if (capture) begin
                    resp_rdata_d = mem_rdata_i;
                    resp_valid_d = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = StIdle;
                    end else begin
                        mem_addr_d = mem_addr_q + ADDR_W'(1);
                        cnt_d      = cnt_q - LEN_W'(1);
                    end
                end
            end
            default: begin
                mem_we_d = 1'b0;
                state_d  = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            wr_done_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            wr_done_q    <= wr_done_d;
        end
    end

    assign req_ready_o  = (state_q == StIdle);
    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = resp_rdata_q;
    assign wr_done_o    = wr_done_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign mem_we_o     = mem_we_q;

endmodule

// File: tb/tb_data_mem_master.sv
// Bench for data_mem_master: behavioural memory plus a word-array reference of its contents;
// read bursts are checked beat by beat against addresses computed from the request.
module tb_data_mem_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [11:0] req_addr;
    logic [15:0] req_wdata;
    logic [3:0]  req_len;
    logic        resp_valid, resp_ready;
    logic [15:0] resp_rdata;
    logic        wr_done;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic [15:0] mem_rdata;

    int n_cmp = 0;
    int n_err = 0;

    // Memory model: never-written words hold a fixed power-on pattern.
    bit [15:0] mem_arr [4096];
    bit        mem_wr  [4096];
    bit [15:0] model_mem [4096];
    bit        model_wr  [4096];
    logic        bd_en = 1'b0;
    logic [11:0] bd_addr = '0;
    logic [15:0] bd_data = '0;

    function automatic logic [15:0] init_pat(input logic [11:0] a);
        return (16'(a) * 16'h9E37) ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] model_val(input logic [11:0] a);
        return model_wr[a] ? model_mem[a] : init_pat(a);
    endfunction

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) begin
            mem_arr[mem_addr] <= mem_wdata;
            mem_wr[mem_addr]  <= 1'b1;
        end else if (bd_en) begin
            mem_arr[bd_addr] <= bd_data;
            mem_wr[bd_addr]  <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!mem_we) mem_rdata <= mem_wr[mem_addr] ? mem_arr[mem_addr] : init_pat(mem_addr);
    end

    data_mem_master dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_we_i     (req_we),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .req_len_i    (req_len),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_rdata_o (resp_rdata),
        .wr_done_o    (wr_done),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_we_o     (mem_we),
        .mem_rdata_i  (mem_rdata)
    );

    // Called at a negedge; returns at the first negedge after the accepting posedge.
    task automatic issue(input logic we, input logic [11:0] a, input logic [15:0] d,
                         input logic [3:0] l, output bit ok);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_len = l;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (req_ready) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) @(negedge clk);
        req_valid = 1'b0;
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL issue: req_ready got 0 for 50 cycles, required 1");
        end
    endtask

    task automatic backdoor(input logic [11:0] a, input logic [15:0] d);
        bd_en = 1'b1; bd_addr = a; bd_data = d;
        @(negedge clk);
        bd_en = 1'b0;
        model_wr[a] = 1'b1; model_mem[a] = d;
    endtask

    task automatic do_write(input logic [11:0] a, input logic [15:0] d);
        bit ok;
        issue(1'b1, a, d, 4'd0, ok);
        if (!ok) return;
        model_wr[a] = 1'b1; model_mem[a] = d;
        n_cmp++;
        if (mem_we !== 1'b1 || mem_addr !== a || mem_wdata !== d || req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL write_drive: we=%b addr=%h data=%h rdy=%b, required 1 %h %h 0",
                     mem_we, mem_addr, mem_wdata, req_ready, a, d);
        end
        @(negedge clk);
        n_cmp++;
        if (wr_done !== 1'b1 || mem_we !== 1'b0 || req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL write_done: wr_done=%b we=%b rdy=%b, required 1 0 1",
                     wr_done, mem_we, req_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (wr_done !== 1'b0) begin
            n_err++;
            $display("FAIL write_pulse: wr_done=%b, required 0", wr_done);
        end
    endtask

    // mode 0: random resp_ready; 1: always ready; 2: stall beat 1 for 3 cycles.
    task automatic read_burst(input logic [11:0] a, input logic [3:0] len, input int mode);
        bit ok;
        int consumed = 0, cyc = 0, stalls = 0;
        bit prev_stall = 1'b0, rr;
        logic [15:0] prev_d = '0;
        logic [11:0] prev_a = '0;
        logic [15:0] exp_d;
        issue(1'b0, a, 16'h0, len, ok);
        if (!ok) return;
        while (consumed <= int'(len) && cyc < 300) begin
            cyc++;
            if (prev_stall) begin
                n_cmp++;
                if (resp_valid !== 1'b1 || resp_rdata !== prev_d || mem_addr !== prev_a) begin
                    n_err++;
                    $display("FAIL stall_hold: v=%b d=%h a=%h, required 1 %h %h",
                             resp_valid, resp_rdata, mem_addr, prev_d, prev_a);
                end
            end
            n_cmp++;
            if (mem_we !== 1'b0 ||
                req_ready !== ((consumed + int'(resp_valid)) == int'(len) + 1)) begin
                n_err++;
                $display("FAIL read_ctrl: we=%b rdy=%b, required 0 %b", mem_we, req_ready,
                         (consumed + int'(resp_valid)) == int'(len) + 1);
            end
            if (mode == 1) rr = 1'b1;
            else if (mode == 2) begin
                rr = !(resp_valid && consumed == 1 && stalls < 3);
                if (!rr) stalls++;
            end else rr = ($urandom_range(0, 3) != 0);
            resp_ready = rr;
            if (resp_valid && rr) begin
                exp_d = model_val(a + 12'(consumed));
                n_cmp++;
                if (resp_rdata !== exp_d) begin
                    n_err++;
                    $display("FAIL beat%0d @%h: got %h, required %h", consumed,
                             a + 12'(consumed), resp_rdata, exp_d);
                end
                consumed++;
            end
            prev_stall = resp_valid && !rr;
            prev_d = resp_rdata;
            prev_a = mem_addr;
            @(negedge clk);
        end
        resp_ready = 1'b1;
        n_cmp++;
        if (consumed != int'(len) + 1) begin
            n_err++;
            $display("FAIL beat_count: got %0d, required %0d", consumed, int'(len) + 1);
        end
        n_cmp++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || mem_addr !== a + 12'(len)) begin
            n_err++;
            $display("FAIL read_end: v=%b rdy=%b addr=%h, required 0 1 %h",
                     resp_valid, req_ready, mem_addr, a + 12'(len));
        end
        if (mode == 1) begin
            n_cmp++;
            if (cyc != int'(len) + 2) begin
                n_err++;
                $display("FAIL read_rate: took %0d cycles, required %0d", cyc, int'(len) + 2);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        req_len = '0; resp_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 12'h0 || mem_wdata !== 16'h0
            || resp_valid !== 1'b0 || resp_rdata !== 16'h0 || wr_done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: rdy=%b we=%b a=%h wd=%h v=%b rd=%h done=%b, required 1 0 0 0 0 0 0",
                     req_ready, mem_we, mem_addr, mem_wdata, resp_valid, resp_rdata, wr_done);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        do_write(12'h010, 16'h00A5);
        read_burst(12'h010, 4'd0, 1);
    endtask

    task automatic test_burst();
        for (int i = 0; i < 4; i++) backdoor(12'(i), 16'(i + 1));
        read_burst(12'h000, 4'd3, 1);
    endtask

    task automatic test_wrap();
        do_write(12'hFFF, 16'hBEEF);
        read_burst(12'hFFF, 4'd2, 1);
    endtask

    task automatic test_stall();
        read_burst(12'h100, 4'd3, 2);
    endtask

    task automatic test_reset_mid_burst();
        bit ok;
        issue(1'b0, 12'h200, 16'h0, 4'd15, ok);
        resp_ready = 1'b1;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (mem_we !== 1'b0 || mem_addr !== 12'h0 || resp_valid !== 1'b0 ||
            resp_rdata !== 16'h0 || wr_done !== 1'b0 || req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL async_reset: we=%b a=%h v=%b rd=%h done=%b rdy=%b, required 0 0 0 0 0 1",
                     mem_we, mem_addr, resp_valid, resp_rdata, wr_done, req_ready);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (resp_valid !== 1'b0 || req_ready !== 1'b1 || mem_addr !== 12'h0) begin
                n_err++;
                $display("FAIL post_reset%0d: v=%b rdy=%b a=%h, required 0 1 0",
                         i, resp_valid, req_ready, mem_addr);
            end
        end
    endtask

    // A held write request is taken every other cycle; mem_we never spans two cycles.
    task automatic test_hold();
        int we_cnt = 0, done_cnt = 0, back2back = 0;
        logic last_we = 1'b0;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 12'h333; req_wdata = 16'h1234;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (mem_we) we_cnt++;
            if (wr_done) done_cnt++;
            if (mem_we && last_we) back2back++;
            last_we = mem_we;
            n_cmp++;
            if (req_ready !== !mem_we) begin
                n_err++;
                $display("FAIL hold_ready%0d: rdy=%b, required %b", i, req_ready, !mem_we);
            end
        end
        req_valid = 1'b0;
        model_wr[12'h333] = 1'b1; model_mem[12'h333] = 16'h1234;
        n_cmp++;
        if (we_cnt != 3 || done_cnt != 3 || back2back != 0) begin
            n_err++;
            $display("FAIL hold_writes: we=%0d done=%0d b2b=%0d, required 3 3 0",
                     we_cnt, done_cnt, back2back);
        end
        @(negedge clk);
        read_burst(12'h333, 4'd0, 1);
    endtask

    task automatic test_random();
        logic [11:0] a;
        for (int i = 0; i < 24; i++) begin
            a = 12'($urandom_range(0, 4095));
            if ($urandom_range(0, 3) == 0) a = 12'hFFF - 12'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) do_write(a, 16'($urandom));
            else read_burst(a, 4'($urandom_range(0, 15)), 0);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_burst();
        test_wrap();
        test_stall();
        test_hold();
        test_random();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
